multichan_ring_buffer: RTL and testbench
========================================

# multichan_ring_buffer

Parametrised, multi-channel successor to the single-channel acoustics ring buffer. It continuously records CHANNELS hydrophone samples per ADC strobe into a circular store. On a trigger it freezes a frame of PRE_TRIG pre-trigger and DEPTH-PRE_TRIG post-trigger samples, then streams the frame channel-interleaved to the FFT/trigger path with a valid/ready handshake.

## Interface
- DATA_W, 10: sample width per channel.
- DEPTH, 256: samples per channel per frame; power of two, ≥4.
- CHANNELS, 4: channel count, ≥1.
- PRE_TRIG, 64: pre-trigger samples kept; 1 ≤ PRE_TRIG < DEPTH.
- clk  in  1  system clock. Single clock domain.
- reset_b  in  1  reset. Asynchronous assert, active-low.
- in_data  in  CHANNELS*DATA_W  packed samples; channel c is bits [c*DATA_W +: DATA_W].
- in_strobe  in  1  sample-ready level from the SPI front end. It may stay high for many clk cycles. Only its rising edge is a sample.
- trigger  in  1  single-cycle trigger request.
- send_frame  in  1  single-cycle request to start readout.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  streamed sample.
- out_chan  out  $clog2(CHANNELS) (min 1)  channel index of out_data.
- out_valid  out  1  out_data is valid.
- out_last  out  1  marks the final beat of the frame.
- frame_ready  out  1  a frame is frozen and waiting for send_frame.
- overflow  out  1  sticky flag: a sample was dropped while the frame was frozen.
- armed  out  1  pre-trigger fill is complete and a trigger will be accepted.

## Operation
- Sample edge: `in_strobe & ~in_strobe_q`, where in_strobe_q is registered. On each edge, all CHANNELS samples are written at wr_ptr and wr_ptr increments mod DEPTH.
- States:
  - FILL (reset state): writes samples and counts fill up to PRE_TRIG. `armed` goes high when fill == PRE_TRIG. A trigger while not armed is ignored.
  - ARMED: writes samples. A trigger latches `start = wr_ptr_after_write - PRE_TRIG` (mod DEPTH), loads post = DEPTH-PRE_TRIG, and moves to POST.
  - POST: each sample edge writes and decrements post. At post == 0 the state moves to HOLD, and frame_ready rises the next cycle.
  - HOLD: sample edges are dropped and set `overflow`. send_frame moves to READ and clears frame_ready.
  - READ: emits DEPTH×CHANNELS beats in order sample 0 ch0, sample 0 ch1, …, sample DEPTH-1 ch CHANNELS-1. The address is `start + sample_idx` mod DEPTH. Sample edges are dropped and set `overflow`. After the last beat is accepted, the state returns to FILL with fill=0.
- If a trigger and a sample edge occur in the same cycle, the sample is written first and counts as the newest pre-trigger sample.
- Triggers in POST, HOLD and READ are ignored. send_frame outside HOLD is ignored.
- `overflow` clears only on the FILL entry that follows READ, or on reset.
- Storage:
  - one DEPTH×(CHANNELS*DATA_W) memory with a registered read port;
  - the channel mux follows the read register;
  - inferable as block RAM, with no reset on the array.

## Timing
- Reset values:
  - outputs: out_valid=0, out_last=0, frame_ready=0, overflow=0, armed=0, out_data=0, out_chan=0;
  - internal: state=FILL, wr_ptr=0, fill=0.
- Reset mid-operation returns to FILL immediately and discards any frame in progress. Memory contents are don't-care.
- Write occurs in the cycle after the in_strobe rising edge is registered, i.e. 1 clk after the edge.
- frame_ready rises 1 clk after the write of the final post-trigger sample.
- First out_valid comes 2 clk after send_frame: one cycle for the address, one for the RAM read.
- out_data/out_chan/out_last stay stable while `out_valid & ~out_ready`.
- The read pipeline prefetches with a one-entry skid so that beats are back-to-back at one per clk when out_ready is held high.
- Full-rate readout takes DEPTH*CHANNELS+1 clk from send_frame to the final accepted beat.
- Pointer wrap is implicit in the $clog2(DEPTH)-bit pointer arithmetic, with no special case.

## Configuration
- RING_BUFFER_TIMESTAMP_EN:
  - Defined:
    - adds output `trig_stamp [31:0]`, the free-running count of sample edges since reset, latched at the accepted trigger;
    - the counter wraps at 2^32;
    - trig_stamp resets to 0.
  - Undefined: the counter and port are absent, and behaviour is otherwise identical.

## Test plan
- Ramp and trigger: DEPTH=16, PRE_TRIG=4, CHANNELS=2. Feed ch0=n, ch1=0x200+n. Trigger after sample n=9 is written, then pulse send_frame once frame_ready rises. Expect 32 beats: ch0 = 6..21 and ch1 = 0x206..0x215, interleaved, with out_last on beat 32.
- Early trigger: trigger after only 2 samples, while armed=0. Expect no state change. A trigger after sample 4 is accepted.
- Wrap: trigger after sample 30 with DEPTH=16. Expect the frame to be samples 27..42, with the addresses wrapping.
- Overflow: 3 sample edges arrive during HOLD. Expect overflow=1, frame contents unchanged, and overflow cleared after READ completes.
- Backpressure: toggle out_ready randomly. Expect identical beat order, no beat dropped or duplicated, and data held stable while stalled.
- Strobe held for 14 clk: expect exactly one write per edge. A reset pulse during POST returns frame_ready=0, armed=0, out_valid=0.

Source files
------------

// File: rtl/multichan_ring_buffer_if.sv
// Output stream bundle of multichan_ring_buffer: one channel sample per beat,
// valid/ready handshake with an end-of-frame marker.
interface multichan_ring_buffer_if #(
   parameter int DATA_W = 10,
   parameter int CHAN_W = 2
);
   logic [DATA_W-1:0] out_data;
   logic [CHAN_W-1:0] out_chan;
   logic              out_valid;
   logic              out_last;
   logic              out_ready;

   modport master (
      output out_data,
      output out_chan,
      output out_valid,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_chan,
      input  out_valid,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/multichan_ring_buffer.sv
// Multi-channel circular sample recorder with triggered frame freeze and
// channel-interleaved readout. RING_BUFFER_TIMESTAMP_EN adds trig_stamp.
module multichan_ring_buffer #(
   parameter int DATA_W   = 10,
   parameter int DEPTH    = 256,
   parameter int CHANNELS = 4,
   parameter int PRE_TRIG = 64
) (
   input  logic                         clk,
   input  logic                         reset_b,
   input  logic [CHANNELS*DATA_W-1:0]   in_data,
   input  logic                         in_strobe,
   input  logic                         trigger,
   input  logic                         send_frame,
   multichan_ring_buffer_if.master      out_if,
   output logic                         frame_ready,
   output logic                         overflow,
   output logic                         armed
`ifdef RING_BUFFER_TIMESTAMP_EN
   ,
   output logic [31:0]                  trig_stamp
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int WW = CHANNELS * DATA_W;

   typedef enum logic [2:0] {FILL, ARMED, POST, HOLD, READ} state_e;

   state_e          state_q, state_d;
   logic            strobe_q;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   fill_q, fill_d;
   logic [AW-1:0]   post_q, post_d;
   logic [AW-1:0]   start_q, start_d;
   logic            ovf_q, ovf_d;
   logic            frdy_q, frdy_d;
   logic [AW:0]     iss_q, iss_d, iss_cur;
   logic            a_v_q, a_v_d;
   logic            a_last_q, a_last_d;
   logic [AW-1:0]   a_addr_q, a_addr_d;
   logic            r_v_q, r_v_d;
   logic            r_last_q, r_last_d;
   logic [CW-1:0]   chan_q, chan_d;
   logic [WW-1:0]   mem [DEPTH];
   logic [WW-1:0]   rd_q;
   logic            edge_s, wr_en, beat, chan_last;
   logic            word_done, last_beat, r_load, issue;

   always_comb begin
      edge_s    = in_strobe & ~strobe_q;
      wr_en     = edge_s & ((state_q == FILL) | (state_q == ARMED) |
                            (state_q == POST));
      beat      = r_v_q & out_if.out_ready;
      chan_last = (chan_q == CW'(CHANNELS - 1));
      word_done = beat & chan_last;
      last_beat = word_done & r_last_q;
      r_load    = a_v_q & (~r_v_q | word_done);
   end

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
      fill_d   = fill_q;
      post_d   = post_q;
      start_d  = start_q;
      ovf_d    = ovf_q;
      unique case (state_q)
         FILL: begin
            if (edge_s) begin
               fill_d = fill_q + AW'(1);
               if (fill_d == AW'(PRE_TRIG)) state_d = ARMED;
            end
         end
         ARMED: begin
            // wr_ptr_d already includes a same-cycle sample
            if (trigger) begin
               start_d = wr_ptr_d - AW'(PRE_TRIG);
               post_d  = AW'(DEPTH - PRE_TRIG);
               state_d = POST;
            end
         end
         POST: begin
            if (edge_s) begin
               post_d = post_q - AW'(1);
               if (post_d == '0) state_d = HOLD;
            end
         end
         HOLD: begin
            if (edge_s) ovf_d = 1'b1;
            if (send_frame) state_d = READ;
         end
         READ: begin
            if (edge_s) ovf_d = 1'b1;
            if (last_beat) begin
               state_d = FILL;
               fill_d  = '0;
               ovf_d   = 1'b0;
            end
         end
         default: state_d = FILL;
      endcase
      frdy_d = (state_d == HOLD);
   end

   // Address stage doubles as the skid entry: a stalled read re-uses it
   always_comb begin
      iss_cur  = (state_q == HOLD) ? '0 : iss_q;
      issue    = ((state_q == HOLD) & send_frame) |
                 ((state_q == READ) & (iss_q < (AW+1)'(DEPTH)) &
                  (~a_v_q | r_load));
      iss_d    = iss_q;
      a_v_d    = a_v_q & ~r_load;
      a_addr_d = a_addr_q;
      a_last_d = a_last_q;
      if (issue) begin
         a_v_d    = 1'b1;
         a_addr_d = start_q + iss_cur[AW-1:0];
         a_last_d = (iss_cur == (AW+1)'(DEPTH - 1));
         iss_d    = iss_cur + (AW+1)'(1);
      end
      r_v_d    = r_v_q & ~word_done;
      r_last_d = r_last_q;
      chan_d   = chan_q;
      if (beat) chan_d = chan_last ? '0 : chan_q + CW'(1);
      if (r_load) begin
         r_v_d    = 1'b1;
         r_last_d = a_last_q;
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q  <= FILL;
         strobe_q <= 1'b0;
         wr_ptr_q <= '0;
         fill_q   <= '0;
         post_q   <= '0;
         start_q  <= '0;
         ovf_q    <= 1'b0;
         frdy_q   <= 1'b0;
         iss_q    <= '0;
         a_v_q    <= 1'b0;
         a_addr_q <= '0;
         a_last_q <= 1'b0;
         r_v_q    <= 1'b0;
         r_last_q <= 1'b0;
         chan_q   <= '0;
      end else begin
         state_q  <= state_d;
         strobe_q <= in_strobe;
         wr_ptr_q <= wr_ptr_d;
         fill_q   <= fill_d;
         post_q   <= post_d;
         start_q  <= start_d;
         ovf_q    <= ovf_d;
         frdy_q   <= frdy_d;
         iss_q    <= iss_d;
         a_v_q    <= a_v_d;
         a_addr_q <= a_addr_d;
         a_last_q <= a_last_d;
         r_v_q    <= r_v_d;
         r_last_q <= r_last_d;
         chan_q   <= chan_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= in_data;
      if (r_load) rd_q <= mem[a_addr_q];
   end

   assign out_if.out_valid = r_v_q;
   assign out_if.out_chan  = chan_q;
   assign out_if.out_last  = r_v_q & r_last_q & chan_last;
   assign out_if.out_data  = r_v_q ?
                             rd_q[int'(chan_q)*DATA_W +: DATA_W] : '0;
   assign frame_ready = frdy_q;
   assign overflow    = ovf_q;
   assign armed       = (state_q == ARMED);

`ifdef RING_BUFFER_TIMESTAMP_EN
   logic [31:0] ts_cnt_q, ts_cnt_d, stamp_q, stamp_d;

   always_comb begin
      ts_cnt_d = ts_cnt_q + 32'(edge_s);
      stamp_d  = stamp_q;
      if ((state_q == ARMED) & trigger) stamp_d = ts_cnt_d;
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         ts_cnt_q <= '0;
         stamp_q  <= '0;
      end else begin
         ts_cnt_q <= ts_cnt_d;
         stamp_q  <= stamp_d;
      end
   end

   assign trig_stamp = stamp_q;
`endif
endmodule

// File: tb/tb_multichan_ring_buffer.sv
// Scoreboard bench for multichan_ring_buffer: DEPTH=16, PRE_TRIG=4,
// CHANNELS=2; ch0 carries n and ch1 carries 0x200+n.
module tb_multichan_ring_buffer;
   localparam int DW  = 10;
   localparam int DEP = 16;
   localparam int CH  = 2;
   localparam int PRE = 4;
   localparam int NB  = DEP * CH;

   logic             clk = 1'b0;
   logic             reset_b = 1'b0;
   logic [CH*DW-1:0] in_data = '0;
   logic             in_strobe = 1'b0;
   logic             trigger = 1'b0;
   logic             send_frame = 1'b0;
   logic             frame_ready, overflow, armed;
`ifdef RING_BUFFER_TIMESTAMP_EN
   logic [31:0]      trig_stamp;
`endif

   int passed = 0;
   int total  = 0;

   logic [DW-1:0] eq_d[$];
   logic          eq_c[$];
   logic          eq_l[$];
   int            wrote[$];

   multichan_ring_buffer_if #(.DATA_W(DW), .CHAN_W(1)) out_if ();

   multichan_ring_buffer #(
      .DATA_W(DW), .DEPTH(DEP), .CHANNELS(CH), .PRE_TRIG(PRE)
   ) dut (
      .clk(clk),
      .reset_b(reset_b),
      .in_data(in_data),
      .in_strobe(in_strobe),
      .trigger(trigger),
      .send_frame(send_frame),
      .out_if(out_if),
      .frame_ready(frame_ready),
      .overflow(overflow),
      .armed(armed)
`ifdef RING_BUFFER_TIMESTAMP_EN
      ,
      .trig_stamp(trig_stamp)
`endif
   );

   always #5 clk = ~clk;

   task automatic feed(input int v, input int hold);
      in_data[0 +: DW]  = DW'(v);
      in_data[DW +: DW] = DW'(32'h200 + v);
      in_strobe = 1'b1;
      repeat (hold) @(posedge clk);
      #1 in_strobe = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic push_sample(input int v, input logic last);
      eq_d.push_back(DW'(v));
      eq_c.push_back(1'b0);
      eq_l.push_back(1'b0);
      eq_d.push_back(DW'(32'h200 + v));
      eq_c.push_back(1'b1);
      eq_l.push_back(last);
   endtask

   task automatic record(input int v, input int hold);
      feed(v, hold);
      wrote.push_back(v);
   endtask

   task automatic fire_trigger();
      trigger = 1'b1;
      @(posedge clk);
      #1 trigger = 1'b0;
      for (int i = wrote.size() - PRE; i < wrote.size(); i++)
         push_sample(wrote[i], 1'b0);
   endtask

   task automatic post_fill(input int v0, input int hold);
      for (int k = 0; k < DEP - PRE; k++) begin
         feed(v0 + k, hold);
         push_sample(v0 + k, k == DEP - PRE - 1);
      end
   endtask

   task automatic drain_frame(input bit rnd, input bit timed);
      int cyc, nbeat;
      bit stalled, done;
      logic [DW-1:0] hd, ed;
      logic hc, hl, ec, el;
      stalled = 1'b0;
      done    = 1'b0;
      nbeat   = 0;
      hd = '0; hc = 1'b0; hl = 1'b0;
      total++;
      if (frame_ready !== 1'b1)
         $display("FAIL frame_ready_pre got %b want 1", frame_ready);
      else passed++;
      send_frame = 1'b1;
      @(posedge clk);
      #1 send_frame = 1'b0;
      cyc = 1;
      total++;
      if ({out_if.out_valid, frame_ready} !== 2'b00)
         $display("FAIL send_cycle1 valid,frame_ready got %b%b want 00",
                  out_if.out_valid, frame_ready);
      else passed++;
      while (!done && cyc < 4000) begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == 2) begin
            total++;
            if (out_if.out_valid !== 1'b1)
               $display("FAIL first_valid got %b want 1", out_if.out_valid);
            else passed++;
         end
         if (stalled) begin
            total++;
            if ({out_if.out_valid, out_if.out_data, out_if.out_chan,
                 out_if.out_last} !== {1'b1, hd, hc, hl})
               $display("FAIL stall_hold got v=%b d=%h c=%0d l=%b want v=1 d=%h c=%0d l=%b",
                        out_if.out_valid, out_if.out_data, out_if.out_chan,
                        out_if.out_last, hd, hc, hl);
            else passed++;
         end
         out_if.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         stalled = 1'b0;
         if (out_if.out_valid && out_if.out_ready) begin
            if (eq_d.size() == 0) begin
               total++;
               $display("FAIL extra_beat got d=%h want no beat", out_if.out_data);
               done = 1'b1;
            end else begin
               ed = eq_d.pop_front();
               ec = eq_c.pop_front();
               el = eq_l.pop_front();
               total++;
               if ({out_if.out_data, out_if.out_chan, out_if.out_last} !== {ed, ec, el})
                  $display("FAIL beat%0d got d=%h c=%0d l=%b want d=%h c=%0d l=%b",
                           nbeat, out_if.out_data, out_if.out_chan,
                           out_if.out_last, ed, ec, el);
               else passed++;
               nbeat++;
               if (eq_d.size() == 0) begin
                  done = 1'b1;
                  if (timed) begin
                     total++;
                     if (cyc != NB + 1)
                        $display("FAIL readout_clks got %0d want %0d", cyc, NB + 1);
                     else passed++;
                  end
               end
            end
         end else if (out_if.out_valid) begin
            stalled = 1'b1;
            hd = out_if.out_data;
            hc = out_if.out_chan;
            hl = out_if.out_last;
         end
      end
      if (!done) begin
         total++;
         $display("FAIL drain_timeout got %0d beats want %0d", nbeat, NB);
      end
      out_if.out_ready = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if ({out_if.out_valid, overflow, armed, frame_ready} !== 4'b0000)
         $display("FAIL after_read valid,ovf,armed,frdy got %b%b%b%b want 0000",
                  out_if.out_valid, overflow, armed, frame_ready);
      else passed++;
      wrote.delete();
   endtask

   task automatic test_reset();
      reset_b = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({out_if.out_valid, out_if.out_last, frame_ready, overflow, armed} !== 5'b0)
         $display("FAIL reset_flags got %b%b%b%b%b want 00000",
                  out_if.out_valid, out_if.out_last, frame_ready, overflow, armed);
      else passed++;
      total++;
      if ({out_if.out_data, out_if.out_chan} !== '0)
         $display("FAIL reset_data got d=%h c=%0d want 0 0",
                  out_if.out_data, out_if.out_chan);
      else passed++;
      reset_b = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_ramp();
      for (int n = 0; n <= 9; n++) record(n, 1);
      total++;
      if (armed !== 1'b1) $display("FAIL ramp_armed got %b want 1", armed);
      else passed++;
      fire_trigger();
      total++;
      if (armed !== 1'b0) $display("FAIL ramp_post_armed got %b want 0", armed);
      else passed++;
      post_fill(10, 1);
      drain_frame(1'b0, 1'b1);
   endtask

   task automatic test_early_trigger();
      record(22, 1);
      record(23, 1);
      total++;
      if (armed !== 1'b0) $display("FAIL early_armed got %b want 0", armed);
      else passed++;
      trigger = 1'b1;
      @(posedge clk);
      #1 trigger = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({armed, frame_ready} !== 2'b00)
         $display("FAIL early_ignored armed,frdy got %b%b want 00", armed, frame_ready);
      else passed++;
      record(24, 1);
      record(25, 1);
      total++;
      if (armed !== 1'b1) $display("FAIL fill4_armed got %b want 1", armed);
      else passed++;
      fire_trigger();
      post_fill(26, 1);
   endtask

   task automatic test_overflow_backpressure();
      total++;
      if ({frame_ready, overflow} !== 2'b10)
         $display("FAIL hold_entry frdy,ovf got %b%b want 10", frame_ready, overflow);
      else passed++;
      for (int i = 0; i < 3; i++) feed(100 + i, 1);
      total++;
      if ({frame_ready, overflow} !== 2'b11)
         $display("FAIL hold_overflow frdy,ovf got %b%b want 11", frame_ready, overflow);
      else passed++;
      drain_frame(1'b1, 1'b0);
   endtask

   task automatic test_reset_in_post();
      for (int n = 38; n <= 43; n++) record(n, 1);
      fire_trigger();
      feed(44, 1);
      feed(45, 1);
      reset_b = 1'b0;
      #2;
      total++;
      if ({frame_ready, armed, out_if.out_valid} !== 3'b000)
         $display("FAIL post_reset frdy,armed,valid got %b%b%b want 000",
                  frame_ready, armed, out_if.out_valid);
      else passed++;
      @(posedge clk);
      #1 reset_b = 1'b1;
      eq_d.delete();
      eq_c.delete();
      eq_l.delete();
      wrote.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic test_wrap_held_strobe();
      for (int n = 0; n <= 2; n++) record(n, 14);
      total++;
      if (armed !== 1'b0) $display("FAIL refill_armed got %b want 0", armed);
      else passed++;
      for (int n = 3; n <= 30; n++) record(n, 14);
      fire_trigger();
      post_fill(31, 14);
      drain_frame(1'b0, 1'b1);
   endtask

   initial begin
      out_if.out_ready = 1'b1;
      test_reset();
      test_ramp();
      test_early_trigger();
      test_overflow_backpressure();
      test_reset_in_post();
      test_wrap_held_strobe();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
